// File: rtl/piso_shift_transmitter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | piso_pkg : shared types and frame-length helper for the PISO transmitter  |
// | Optional feature macro: PISO_PARITY_EN (appends one even-parity bit).     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    function automatic int frame_len(input int width);
`ifdef PISO_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_shift_transmitter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | piso_shift_transmitter_if : load handshake and serial-side outputs        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface piso_shift_transmitter_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             serial_out;
    logic             shift_active;
    logic             done;

    modport master (
        output data_in, load_valid,
        input  load_ready, serial_out, shift_active, done
    );

    modport slave (
        input  data_in, load_valid,
        output load_ready, serial_out, shift_active, done
    );
endinterface
`default_nettype wire

// File: rtl/piso_shift_transmitter_bit_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | piso_bit_counter : clear/increment frame bit counter with terminal flag   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module piso_bit_counter #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clear,
    input  wire logic inc,
    output logic      terminal
);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign terminal = (r_count == c_last);
endmodule
`default_nettype wire

// File: rtl/piso_shift_transmitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | piso_shift_transmitter : valid/ready parallel-in, serial-out transmitter  |
// | Optional feature macro: PISO_PARITY_EN (even parity bit after the data).  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module piso_shift_transmitter
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  wire logic                clk,
    input  wire logic                reset,
    piso_shift_transmitter_if.slave  link
);
    localparam int c_frame_len = frame_len(WIDTH);
    localparam int c_cnt_w     = $clog2(c_frame_len + 1);

    piso_state_t              r_state;
    piso_state_t              w_state_next;
    logic [c_frame_len-1:0]   r_sr;
    logic [c_frame_len-1:0]   w_load_word;
    logic [c_frame_len-1:0]   w_sr_rotated;
    logic                     w_first_bit;
    logic                     w_next_bit;
    logic                     r_serial;
    logic                     r_active;
    logic                     r_done;
    logic                     w_terminal;
    logic                     w_load_ready;
    logic                     w_load;
    logic                     w_shift;
    logic                     w_end;

    // The parity bit rides in an extra shift-register stage at the tail of the frame.
`ifdef PISO_PARITY_EN
    logic w_parity;
    assign w_parity = ^link.data_in;
`endif

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
`ifdef PISO_PARITY_EN
            assign w_load_word = {link.data_in, w_parity};
`else
            assign w_load_word = link.data_in;
`endif
            assign w_first_bit  = w_load_word[c_frame_len-1];
            assign w_next_bit   = r_sr[c_frame_len-2];
            assign w_sr_rotated = {r_sr[c_frame_len-2:0], r_sr[c_frame_len-1]};
        end else begin : g_lsb_first
`ifdef PISO_PARITY_EN
            assign w_load_word = {w_parity, link.data_in};
`else
            assign w_load_word = link.data_in;
`endif
            assign w_first_bit  = w_load_word[0];
            assign w_next_bit   = r_sr[1];
            assign w_sr_rotated = {r_sr[0], r_sr[c_frame_len-1:1]};
        end
    endgenerate

    piso_bit_counter #(
        .FRAME_LEN (c_frame_len),
        .CNT_W     (c_cnt_w)
    ) u_bit_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_load | w_end),
        .inc      (w_shift),
        .terminal (w_terminal)
    );

    // Ready on the last bit cycle lets the next word follow with no idle gap.
    assign w_load_ready = (r_state == IDLE) || ((r_state == SHIFT) && w_terminal);
    assign w_load       = link.load_valid && w_load_ready;

    always_comb begin
        w_state_next = r_state;
        w_shift      = 1'b0;
        w_end        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_terminal) begin
                    w_end = 1'b1;
                    if (!w_load) begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_shift = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sr     <= '0;
            r_serial <= 1'b0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_end;
            if (w_load) begin
                r_sr     <= w_load_word;
                r_serial <= w_first_bit;
                r_active <= 1'b1;
            end else if (w_end) begin
                r_serial <= 1'b0;
                r_active <= 1'b0;
            end else if (w_shift) begin
                r_sr     <= w_sr_rotated;
                r_serial <= w_next_bit;
            end
        end
    end

    assign link.load_ready   = w_load_ready;
    assign link.serial_out   = r_serial;
    assign link.shift_active = r_active;
    assign link.done         = r_done;
endmodule
`default_nettype wire

// File: tb/tb_piso_shift_transmitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_piso_shift_transmitter : directed checks on MSB- and LSB-first builds  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_piso_shift_transmitter;
`ifdef PISO_PARITY_EN
    localparam int c_fl = 9;
`else
    localparam int c_fl = 8;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       load_valid;
    int         n_checks;
    int         n_fail;

    piso_shift_transmitter_if #(.WIDTH(8)) if_msb ();
    piso_shift_transmitter_if #(.WIDTH(8)) if_lsb ();

    assign if_msb.data_in    = data_in;
    assign if_msb.load_valid = load_valid;
    assign if_lsb.data_in    = data_in;
    assign if_lsb.load_valid = load_valid;

    piso_shift_transmitter #(.WIDTH(8), .MSB_FIRST(1)) u_dut_msb (
        .clk   (clk),
        .reset (reset),
        .link  (if_msb)
    );

    piso_shift_transmitter #(.WIDTH(8), .MSB_FIRST(0)) u_dut_lsb (
        .clk   (clk),
        .reset (reset),
        .link  (if_lsb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input logic [7:0] w, input int k, input bit msb);
        if (k >= 8) return ^w;
        return msb ? w[7-k] : w[k];
    endfunction

    // Entered in cycle 1 of a frame; returns the data bits in arrival order.
    task automatic frame(input logic [7:0] w, input bit done_now, input bit busy,
                         input bit chain, input logic [7:0] nw,
                         output logic [7:0] col_m, output logic [7:0] col_l,
                         output logic par_m, output logic par_l);
        col_m = '0;
        col_l = '0;
        par_m = 1'b0;
        par_l = 1'b0;
        chk("done_first_msb", if_msb.done, done_now);
        chk("done_first_lsb", if_lsb.done, done_now);
        for (int k = 0; k < c_fl; k++) begin
            if (busy && k >= 1 && k <= 4) begin
                load_valid = 1'b1;
                data_in    = 8'h00;
            end else if (chain && k == c_fl - 1) begin
                load_valid = 1'b1;
                data_in    = nw;
            end else begin
                load_valid = 1'b0;
            end
            chk("bit_msb", if_msb.serial_out, exp_bit(w, k, 1'b1));
            chk("bit_lsb", if_lsb.serial_out, exp_bit(w, k, 1'b0));
            chk("active", if_msb.shift_active & if_lsb.shift_active, 1);
            chk("ready_msb", if_msb.load_ready, (k == c_fl - 1));
            chk("ready_lsb", if_lsb.load_ready, (k == c_fl - 1));
            if (k > 0) chk("done_mid", if_msb.done | if_lsb.done, 0);
            if (k < 8) begin
                col_m = {col_m[6:0], if_msb.serial_out};
                col_l = {col_l[6:0], if_lsb.serial_out};
            end else begin
                par_m = if_msb.serial_out;
                par_l = if_lsb.serial_out;
            end
            step();
        end
        if (!chain) begin
            load_valid = 1'b0;
            chk("done_end_msb", if_msb.done, 1);
            chk("done_end_lsb", if_lsb.done, 1);
            chk("idle_active", if_msb.shift_active | if_lsb.shift_active, 0);
            chk("idle_serial", if_msb.serial_out | if_lsb.serial_out, 0);
            chk("idle_ready", if_msb.load_ready & if_lsb.load_ready, 1);
            step();
            chk("done_drop", if_msb.done | if_lsb.done, 0);
        end
    endtask

    task automatic load(input logic [7:0] w);
        data_in    = w;
        load_valid = 1'b1;
        chk("ready_idle", if_msb.load_ready & if_lsb.load_ready, 1);
        step();
    endtask

    initial begin
        logic [7:0] cm, cl;
        logic       pm, pl;
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b0;
        data_in    = 8'h00;
        load_valid = 1'b0;
        step();
        step();
        chk("rst_serial", if_msb.serial_out | if_lsb.serial_out, 0);
        chk("rst_active", if_msb.shift_active | if_lsb.shift_active, 0);
        chk("rst_done", if_msb.done | if_lsb.done, 0);
        chk("rst_ready", if_msb.load_ready & if_lsb.load_ready, 1);
        reset = 1'b1;
        step();
        chk("done_after_rel", if_msb.done | if_lsb.done, 0);

        // Single frame 0xB4
        load(8'hB4);
        frame(8'hB4, 1'b0, 1'b0, 1'b0, 8'h00, cm, cl, pm, pl);
        chk("b4_msb_word", cm, 8'hB4);
        chk("b4_lsb_word", cl, 8'h2D);
`ifdef PISO_PARITY_EN
        chk("b4_parity_msb", pm, 0);
        chk("b4_parity_lsb", pl, 0);
`endif

        // Back-to-back 0xB4 then 0x0F
        load(8'hB4);
        frame(8'hB4, 1'b0, 1'b0, 1'b1, 8'h0F, cm, cl, pm, pl);
        chk("b2b1_msb_word", cm, 8'hB4);
        chk("b2b1_lsb_word", cl, 8'h2D);
        frame(8'h0F, 1'b1, 1'b0, 1'b0, 8'h00, cm, cl, pm, pl);
        chk("b2b2_msb_word", cm, 8'h0F);
        chk("b2b2_lsb_word", cl, 8'hF0);

        // Busy: 0x00 offered while 0xFF is in flight must be ignored
        load(8'hFF);
        frame(8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, cm, cl, pm, pl);
        chk("busy_msb_word", cm, 8'hFF);
        chk("busy_lsb_word", cl, 8'hFF);
        chk("busy_no_reload", if_msb.shift_active | if_lsb.shift_active, 0);

        // Reset in cycle 4 of a frame
        load(8'hB4);
        load_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("pre_rst_bit", if_msb.serial_out, exp_bit(8'hB4, k, 1'b1));
            step();
        end
        reset = 1'b0;
        #1;
        chk("mid_rst_serial", if_msb.serial_out | if_lsb.serial_out, 0);
        chk("mid_rst_active", if_msb.shift_active | if_lsb.shift_active, 0);
        chk("mid_rst_done", if_msb.done | if_lsb.done, 0);
        step();
        step();
        reset = 1'b1;
        chk("post_rst_ready", if_msb.load_ready & if_lsb.load_ready, 1);
        step();
        chk("post_rst_done", if_msb.done | if_lsb.done, 0);
        chk("post_rst_active", if_msb.shift_active | if_lsb.shift_active, 0);
        load(8'h81);
        frame(8'h81, 1'b0, 1'b0, 1'b0, 8'h00, cm, cl, pm, pl);
        chk("x81_msb_word", cm, 8'h81);
        chk("x81_lsb_word", cl, 8'h81);

        // 0x07: three ones, odd weight
        load(8'h07);
        frame(8'h07, 1'b0, 1'b0, 1'b0, 8'h00, cm, cl, pm, pl);
        chk("x07_msb_word", cm, 8'h07);
        chk("x07_lsb_word", cl, 8'hE0);
`ifdef PISO_PARITY_EN
        chk("x07_parity_msb", pm, 1);
        chk("x07_parity_lsb", pl, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
